// File: rtl/param_dual_port_ram_if.sv
// Bus bundle for param_dual_port_ram: one write port (A), one read port (B)
// and the clear-sweep status flag. The master drives accesses; the RAM is the slave.
interface param_dual_port_ram_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  logic                  wena;
  logic [ADDR_W-1:0]     addra;
  logic [DATA_W-1:0]     dina;
  logic [DATA_W/8-1:0]   bea;
  logic                  renb;
  logic [ADDR_W-1:0]     addrb;
  logic [DATA_W-1:0]     doutb;
  logic                  dvalb;
  logic                  collb;
  logic                  busy;

  modport master (
    output wena, addra, dina, bea, renb, addrb,
    input  doutb, dvalb, collb, busy
  );

  modport slave (
    input  wena, addra, dina, bea, renb, addrb,
    output doutb, dvalb, collb, busy
  );
endinterface

// File: rtl/param_dual_port_ram.sv
// Simple dual-port RAM: byte-enabled write port A, pipelined read port B
// (latency 1 or 2), selectable read-old / write-through collision behaviour,
// and an optional zeroing sweep of the whole array after reset.
module param_dual_port_ram #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 10,
  parameter int RD_LAT     = 1,
  parameter int WR_FIRST   = 0,
  parameter int CLR_ON_RST = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  param_dual_port_ram_if.slave   bus
);

  localparam int NBYTES = DATA_W / 8;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic {CLEAR, READY} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                busy_q, busy_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [NBYTES-1:0]   wr_be;

  logic                rd_acc;
  logic                coll;
  logic [DATA_W-1:0]   rd_word;

  logic                vld1_q, vld1_d;
  logic                col1_q, col1_d;
  logic [DATA_W-1:0]   dat1_q, dat1_d;

  // Next-state logic for the clear sweep: walk every address once, then park in READY.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    if (state_q == CLEAR) begin
      if (cnt_q == '1) begin
        state_d = READY;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + ADDR_W'(1);
      end
    end
  end

  // FSM state, sweep counter and registered busy flag.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      state_q <= (CLR_ON_RST != 0) ? CLEAR : READY;
      cnt_q   <= '0;
      busy_q  <= (CLR_ON_RST != 0);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Single physical write port shared by the sweep (zero fill) and port A.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = bus.addra;
    wr_data = bus.dina;
    wr_be   = bus.bea;
    if (!rst) begin
      if (state_q == CLEAR) begin
        wr_en   = 1'b1;
        wr_addr = cnt_q;
        wr_data = '0;
        wr_be   = '1;
      end else begin
        wr_en   = bus.wena;
      end
    end
  end

  // Storage array with per-byte write enables.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset term; clearing is done by the sweep so it maps onto block RAM.
    if (wr_en) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (wr_be[i]) mem_q[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Read acceptance, collision detection and the word handed to the pipeline.
  always_comb begin
    rd_acc  = bus.renb && (state_q == READY);
    coll    = rd_acc && bus.wena && (bus.addra == bus.addrb);
    rd_word = mem_q[bus.addrb];
    if ((WR_FIRST != 0) && coll) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (bus.bea[i]) rd_word[8*i +: 8] = bus.dina[8*i +: 8];
      end
    end
    vld1_d = rd_acc;
    col1_d = coll;
    dat1_d = rd_acc ? rd_word : dat1_q;
  end

  // First read stage; data only moves on an accepted read so it holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld1_q <= 1'b0;
      col1_q <= 1'b0;
      dat1_q <= '0;
    end else begin
      vld1_q <= vld1_d;
      col1_q <= col1_d;
      dat1_q <= dat1_d;
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic                vld2_q, vld2_d;
      logic                col2_q, col2_d;
      logic [DATA_W-1:0]   dat2_q, dat2_d;

      // Second stage advances only behind a valid first stage.
      always_comb begin
        vld2_d = vld1_q;
        col2_d = vld1_q && col1_q;
        dat2_d = vld1_q ? dat1_q : dat2_q;
      end

      // Output register for two-cycle latency.
      always_ff @(posedge clk) begin
        if (rst) begin
          vld2_q <= 1'b0;
          col2_q <= 1'b0;
          dat2_q <= '0;
        end else begin
          vld2_q <= vld2_d;
          col2_q <= col2_d;
          dat2_q <= dat2_d;
        end
      end

      assign bus.dvalb = vld2_q;
      assign bus.collb = col2_q;
      assign bus.doutb = dat2_q;
    end else begin : g_lat1
      assign bus.dvalb = vld1_q;
      assign bus.collb = col1_q;
      assign bus.doutb = dat1_q;
    end
  endgenerate

  assign bus.busy = busy_q;

endmodule

// File: tb/tb_param_dual_port_ram.sv
// Directed bench for param_dual_port_ram. Group A: default instance (u0) and a
// write-through, two-cycle-latency instance (u1) share stimulus. Group B: a
// 16-word clearing instance (u2) and a 16-word non-clearing instance (u3).
module tb_param_dual_port_ram;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic        a_wena, a_renb;
  logic [9:0]  a_addra, a_addrb;
  logic [31:0] a_dina;
  logic [3:0]  a_bea;
  logic        b_wena, b_renb;
  logic [3:0]  b_addra, b_addrb;
  logic [31:0] b_dina;
  logic [3:0]  b_bea;

  param_dual_port_ram_if #(.DATA_W(32), .ADDR_W(10)) if0 ();
  param_dual_port_ram_if #(.DATA_W(32), .ADDR_W(10)) if1 ();
  param_dual_port_ram_if #(.DATA_W(32), .ADDR_W(4))  if2 ();
  param_dual_port_ram_if #(.DATA_W(32), .ADDR_W(4))  if3 ();

  assign if0.wena = a_wena;  assign if0.addra = a_addra; assign if0.dina = a_dina;
  assign if0.bea  = a_bea;   assign if0.renb  = a_renb;  assign if0.addrb = a_addrb;
  assign if1.wena = a_wena;  assign if1.addra = a_addra; assign if1.dina = a_dina;
  assign if1.bea  = a_bea;   assign if1.renb  = a_renb;  assign if1.addrb = a_addrb;
  assign if2.wena = b_wena;  assign if2.addra = b_addra; assign if2.dina = b_dina;
  assign if2.bea  = b_bea;   assign if2.renb  = b_renb;  assign if2.addrb = b_addrb;
  assign if3.wena = b_wena;  assign if3.addra = b_addra; assign if3.dina = b_dina;
  assign if3.bea  = b_bea;   assign if3.renb  = b_renb;  assign if3.addrb = b_addrb;

  param_dual_port_ram #(.DATA_W(32), .ADDR_W(10), .RD_LAT(1), .WR_FIRST(0), .CLR_ON_RST(1))
    u0 (.clk(clk), .rst(rst_a), .bus(if0.slave));
  param_dual_port_ram #(.DATA_W(32), .ADDR_W(10), .RD_LAT(2), .WR_FIRST(1), .CLR_ON_RST(1))
    u1 (.clk(clk), .rst(rst_a), .bus(if1.slave));
  param_dual_port_ram #(.DATA_W(32), .ADDR_W(4), .RD_LAT(1), .WR_FIRST(0), .CLR_ON_RST(1))
    u2 (.clk(clk), .rst(rst_b), .bus(if2.slave));
  param_dual_port_ram #(.DATA_W(32), .ADDR_W(4), .RD_LAT(1), .WR_FIRST(0), .CLR_ON_RST(0))
    u3 (.clk(clk), .rst(rst_b), .bus(if3.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_a(input logic [9:0] addr, input logic [31:0] data, input logic [3:0] be);
    a_wena = 1'b1; a_addra = addr; a_dina = data; a_bea = be;
    cyc();
    a_wena = 1'b0; a_bea = 4'h0;
  endtask

  // Single read on group A; checks u0 after 1 cycle and u1 after 2 cycles.
  task automatic rd_a(input logic [9:0] addr, input logic [31:0] exp, input string tag);
    a_renb = 1'b1; a_addrb = addr;
    cyc();
    a_renb = 1'b0;
    check({tag, " u0 dval"}, {31'd0, if0.dvalb}, 32'd1);
    check({tag, " u0 data"}, if0.doutb, exp);
    check({tag, " u0 coll"}, {31'd0, if0.collb}, 32'd0);
    check({tag, " u1 early"}, {31'd0, if1.dvalb}, 32'd0);
    cyc();
    check({tag, " u0 dval off"}, {31'd0, if0.dvalb}, 32'd0);
    check({tag, " u0 hold"}, if0.doutb, exp);
    check({tag, " u1 dval"}, {31'd0, if1.dvalb}, 32'd1);
    check({tag, " u1 data"}, if1.doutb, exp);
    check({tag, " u1 coll"}, {31'd0, if1.collb}, 32'd0);
  endtask

  initial begin
    int  n;
    logic saw;

    rst_a = 1'b1; rst_b = 1'b1;
    a_wena = 0; a_renb = 0; a_addra = 0; a_addrb = 0; a_dina = 0; a_bea = 0;
    b_wena = 0; b_renb = 0; b_addra = 0; b_addrb = 0; b_dina = 0; b_bea = 0;
    repeat (3) cyc();

    // Reset state
    check("rst u0 busy",  {31'd0, if0.busy},  32'd1);
    check("rst u0 dval",  {31'd0, if0.dvalb}, 32'd0);
    check("rst u0 dout",  if0.doutb,          32'd0);
    check("rst u0 coll",  {31'd0, if0.collb}, 32'd0);
    check("rst u1 busy",  {31'd0, if1.busy},  32'd1);
    check("rst u2 busy",  {31'd0, if2.busy},  32'd1);
    check("rst u3 busy",  {31'd0, if3.busy},  32'd0);

    // Group B: reset mid-sweep at count 7 restarts the full 16-cycle sweep
    rst_b = 1'b0; b_renb = 1'b1; b_addrb = 4'd3;
    saw = 1'b0;
    repeat (7) begin
      cyc();
      if (if2.dvalb) saw = 1'b1;
    end
    check("u2 busy mid-sweep", {31'd0, if2.busy}, 32'd1);
    rst_b = 1'b1;
    cyc();
    check("u2 busy in rst", {31'd0, if2.busy}, 32'd1);
    rst_b = 1'b0;
    n = 0;
    while (if2.busy && n < 100) begin
      cyc();
      n++;
      if (if2.dvalb) saw = 1'b1;
    end
    b_renb = 1'b0;
    check("u2 busy cycles", n, 32'd16);
    check("u2 no dval in busy", {31'd0, saw}, 32'd0);
    check("u3 ready", {31'd0, if3.busy}, 32'd0);

    // Group B: write/read after sweep, then re-clear
    b_wena = 1'b1; b_addra = 4'd5; b_dina = 32'hDEADBEEF; b_bea = 4'hF;
    cyc();
    b_wena = 1'b0; b_renb = 1'b1; b_addrb = 4'd5;
    cyc();
    b_renb = 1'b0;
    check("u2 rd5 dval", {31'd0, if2.dvalb}, 32'd1);
    check("u2 rd5 data", if2.doutb, 32'hDEADBEEF);
    check("u3 rd5 data", if3.doutb, 32'hDEADBEEF);
    rst_b = 1'b1;
    cyc();
    check("u2 dout in rst", if2.doutb, 32'd0);
    rst_b = 1'b0;
    n = 0;
    while (if2.busy && n < 100) begin cyc(); n++; end
    check("u2 busy cycles 2", n, 32'd16);
    b_renb = 1'b1; b_addrb = 4'd5;
    cyc();
    b_renb = 1'b0;
    check("u2 rd5 cleared", if2.doutb, 32'd0);

    // Group A: full 1024-word sweep; reads during busy are ignored
    rst_a = 1'b0; a_renb = 1'b1; a_addrb = 10'd1;
    n = 0; saw = 1'b0;
    while (if0.busy && n < 2000) begin
      cyc();
      n++;
      if (if0.dvalb || if1.dvalb) saw = 1'b1;
    end
    a_renb = 1'b0;
    check("u0 busy cycles", n, 32'd1024);
    check("u1 busy", {31'd0, if1.busy}, 32'd0);
    check("A no dval in busy", {31'd0, saw}, 32'd0);

    // Basic write/read, overwrite, cleared address
    wr_a(10'h001, 32'h55, 4'hF);
    rd_a(10'h001, 32'h00000055, "rd1");
    wr_a(10'h001, 32'h22, 4'hF);
    rd_a(10'h001, 32'h00000022, "rd1b");
    rd_a(10'h3FF, 32'h00000000, "rd3ff");

    // Byte enables, and bea=0 leaves memory unchanged
    wr_a(10'h002, 32'h11223344, 4'hF);
    wr_a(10'h002, 32'hAABBCCDD, 4'b0101);
    rd_a(10'h002, 32'h11BB33DD, "be");
    wr_a(10'h002, 32'hFFFFFFFF, 4'b0000);
    rd_a(10'h002, 32'h11BB33DD, "be0");

    // Full-word collision at 0x001: u0 read-old, u1 write-through
    a_wena = 1; a_addra = 10'h001; a_dina = 32'h99; a_bea = 4'hF;
    a_renb = 1; a_addrb = 10'h001;
    cyc();
    a_wena = 0; a_renb = 0; a_bea = 0;
    check("col u0 dval", {31'd0, if0.dvalb}, 32'd1);
    check("col u0 data", if0.doutb, 32'h00000022);
    check("col u0 coll", {31'd0, if0.collb}, 32'd1);
    check("col u1 coll early", {31'd0, if1.collb}, 32'd0);
    cyc();
    check("col u0 coll off", {31'd0, if0.collb}, 32'd0);
    check("col u1 dval", {31'd0, if1.dvalb}, 32'd1);
    check("col u1 data", if1.doutb, 32'h00000099);
    check("col u1 coll", {31'd0, if1.collb}, 32'd1);

    // Partial collision at 0x002: only the top byte written
    a_wena = 1; a_addra = 10'h002; a_dina = 32'h0; a_bea = 4'b1000;
    a_renb = 1; a_addrb = 10'h002;
    cyc();
    a_wena = 0; a_renb = 0; a_bea = 0;
    check("pcol u0 data", if0.doutb, 32'h11BB33DD);
    check("pcol u0 coll", {31'd0, if0.collb}, 32'd1);
    cyc();
    check("pcol u1 data", if1.doutb, 32'h00BB33DD);
    check("pcol u1 coll", {31'd0, if1.collb}, 32'd1);

    // Back-to-back reads 0x001, 0x002, 0x003
    wr_a(10'h003, 32'h33333333, 4'hF);
    a_renb = 1; a_addrb = 10'h001;
    cyc();
    check("b2b u0 d1", if0.doutb, 32'h00000099);
    check("b2b u1 v0", {31'd0, if1.dvalb}, 32'd0);
    a_addrb = 10'h002;
    cyc();
    check("b2b u0 d2", if0.doutb, 32'h00BB33DD);
    check("b2b u1 v1", {31'd0, if1.dvalb}, 32'd1);
    check("b2b u1 d1", if1.doutb, 32'h00000099);
    a_addrb = 10'h003;
    cyc();
    a_renb = 0;
    check("b2b u0 d3", if0.doutb, 32'h33333333);
    check("b2b u1 v2", {31'd0, if1.dvalb}, 32'd1);
    check("b2b u1 d2", if1.doutb, 32'h00BB33DD);
    cyc();
    check("b2b u0 v off", {31'd0, if0.dvalb}, 32'd0);
    check("b2b u1 v3", {31'd0, if1.dvalb}, 32'd1);
    check("b2b u1 d3", if1.doutb, 32'h33333333);
    cyc();
    check("b2b u1 v off", {31'd0, if1.dvalb}, 32'd0);
    check("b2b u1 hold", if1.doutb, 32'h33333333);

    // In-flight read dropped by reset
    a_renb = 1; a_addrb = 10'h003;
    cyc();
    a_renb = 0; rst_a = 1'b1;
    cyc();
    check("flush u1 dval", {31'd0, if1.dvalb}, 32'd0);
    check("flush u1 dout", if1.doutb, 32'd0);
    check("flush u0 dout", if0.doutb, 32'd0);
    check("flush u0 busy", {31'd0, if0.busy}, 32'd1);
    rst_a = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/param_dual_port_ram.md
PARAM_DUAL_PORT_RAM -- requirements
Module: param_dual_port_ram

Interface
REQ-001 Parameter DATA_W, default 32: data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 10: address width; depth SHALL be 2**ADDR_W words.
REQ-003 Parameter RD_LAT, default 1: read latency in cycles, legal values 1 or 2.
REQ-004 Parameter WR_FIRST, default 0: collision mode; 0 = read-old, 1 = write-through.
REQ-005 Parameter CLR_ON_RST, default 1: 1 = zero the whole array after reset.
REQ-006 clk  in  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-007 rst  in  1  reset; synchronous, active-high.
REQ-008 wena  in  1  port A write enable.
REQ-009 addra  in  ADDR_W  port A write address.
REQ-010 dina  in  DATA_W  port A write data.
REQ-011 bea  in  DATA_W/8  port A byte enables; bit i covers dina[8i+7:8i].
REQ-012 renb  in  1  port B read enable.
REQ-013 addrb  in  ADDR_W  port B read address.
REQ-014 doutb  out  DATA_W  port B read data.
REQ-015 dvalb  out  1  doutb valid strobe.
REQ-016 collb  out  1  read collided with a same-cycle write to the same address.
REQ-017 busy  out  1  clear sweep in progress; accesses are ignored while high.

Function
REQ-018 Write: when wena=1, busy=0 and bea[i]=1 at a clk edge, byte i of mem[addra] SHALL take dina byte i; bytes with bea[i]=0 SHALL be unchanged.
REQ-019 wena=1 with bea=0 SHALL leave memory unchanged.
REQ-020 Read accepted: renb=1 and busy=0 at edge N.
REQ-021 For an accepted read, dvalb SHALL be 1 for exactly one cycle, after edge N+RD_LAT-1, with doutb = mem[addrb] as sampled at edge N.
REQ-022 Reads SHALL be fully pipelined: one accepted read per cycle yields dvalb high on consecutive cycles, in order.
REQ-023 doutb SHALL hold its last valid value while dvalb=0.
REQ-024 Collision: wena=1, renb=1 and addra==addrb at the same edge.
REQ-025 On collision with WR_FIRST=0, doutb SHALL be the pre-write word.
REQ-026 On collision with WR_FIRST=1, doutb SHALL be the post-write word: enabled bytes from dina, other bytes old.
REQ-027 On collision, collb SHALL be asserted in the same cycle as that read's dvalb; otherwise collb SHALL be 0.
REQ-028 The FSM SHALL have two states: CLEAR and READY.
REQ-029 In CLEAR, a counter SHALL write zero to address 0, 1, ... 2**ADDR_W-1, one address per cycle, with busy=1.
REQ-030 After the last address is written, the FSM SHALL move to READY on the next edge; busy SHALL deassert, giving a total of 2**ADDR_W busy cycles.
REQ-031 In CLEAR, wena and renb SHALL be ignored; no dvalb is produced.
REQ-032 With CLR_ON_RST=0, the FSM SHALL go straight to READY and the memory contents SHALL be unspecified.
REQ-033 The counter SHALL wrap only via the FSM exit; there SHALL be no wrap back to CLEAR.

Reset
REQ-034 While rst=1: doutb=0, dvalb=0 and collb=0; the read pipeline is flushed and in-flight reads are dropped.
REQ-035 While rst=1, the FSM SHALL go to CLEAR (CLR_ON_RST=1) or READY (CLR_ON_RST=0), and the counter SHALL be 0.
REQ-036 Reset asserted mid-clear SHALL restart the sweep from address 0.
REQ-037 Writes SHALL be blocked while rst=1.

Verification
REQ-038 Defaults, after the clear sweep: write 0x55 to 0x001 with bea=0xF, then read 0x001 -> dvalb after 1 cycle, doutb=0x00000055, collb=0.
REQ-039 Overwrite 0x001 with 0x22, then read 0x001 -> doutb=0x00000022; an unwritten address 0x3FF -> 0x00000000 (cleared).
REQ-040 Byte enable: mem[0x002]=0x11223344, then write 0xAABBCCDD with bea=0b0101 -> read 0x002 returns 0x11BB33DD.
REQ-041 Collision at 0x001 (old 0x22, new 0x99, bea=0xF) -> WR_FIRST=0 returns 0x22, WR_FIRST=1 returns 0x99; collb=1 with dvalb in both cases.
REQ-042 RD_LAT=2, back-to-back reads of 0x001, 0x002, 0x003 -> dvalb high for 3 consecutive cycles starting 2 cycles after the first read, with data in order.
REQ-043 ADDR_W=4: assert rst mid-sweep at count 7 -> busy stays high 16 cycles after rst deasserts; reads issued during busy produce no dvalb.
